// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan sequencer.
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} scan_state_t;
  localparam int N_CH_DEF  = 4;
  localparam int SEL_W_DEF = 2;
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control/observation bundle between a scan sequencer and its user/mux.
interface mux_scan_sequencer_if
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = 8
);
  logic             start;
  logic             continuous;
  logic             y_in;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [N_CH-1:0]  sample;
  logic             valid;
  logic [CNT_W-1:0] frame_cnt;

  modport master (output start, continuous, y_in,
                  input  sel, busy, sample, valid, frame_cnt);
  modport slave  (input  start, continuous, y_in,
                  output sel, busy, sample, valid, frame_cnt);
endinterface

// File: rtl/dwell_timer.sv
// Reloading down-counter: tc_o marks the last cycle of each DWELL-cycle window.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tc_o
);
  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (clr_i || tc_o) cnt_d = LOAD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a mux select through every channel, captures y_in per channel and
// publishes one parallel frame word per completed scan.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  mux_scan_sequencer_if.slave bus
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  scan_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  sample_q, sample_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             tc;

  // Timer is held loaded outside RUN so every channel gets a full window.
  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != RUN),
    .tc_o  (tc)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shadow_d    = shadow_q;
    sample_d    = sample_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN: if (tc) begin
        shadow_d[sel_q] = bus.y_in;
        // shadow_d already carries the last channel's bit, so publish it directly
        if (sel_q == LAST) begin
          state_d  = DONE;
          sample_d = shadow_d;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end
      DONE: begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        sel_d       = '0;
        state_d     = bus.continuous ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      shadow_q    <= '0;
      sample_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      sample_q    <= sample_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.valid     = (state_q == DONE);
  assign bus.sample    = sample_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: DWELL=4 instance (a) and DWELL=1/CNT_W=2 instance (b)
// checked every cycle against a frame-timeline model plus directed literals.
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic st [2];
  logic ct [2];
  logic vld [2];
  logic [3:0] vec_a, vec_b;
  int n_cmp = 0;
  int n_err = 0;
  int lat, nv;

  always #5 clk = ~clk;

  mux_scan_sequencer_if #(.N_CH(4), .SEL_W(2), .CNT_W(8)) if_a ();
  mux_scan_sequencer_if #(.N_CH(4), .SEL_W(2), .CNT_W(2)) if_b ();

  mux_scan_sequencer #(.N_CH(4), .SEL_W(2), .DWELL(4), .CNT_W(8)) u_a (
    .clk(clk), .reset(rst_a), .bus(if_a.slave));
  mux_scan_sequencer #(.N_CH(4), .SEL_W(2), .DWELL(1), .CNT_W(2)) u_b (
    .clk(clk), .reset(rst_b), .bus(if_b.slave));

  // behavioural 4:1 muxes feeding the scanners; vec bit i is channel i
  assign if_a.y_in       = vec_a[if_a.sel];
  assign if_b.y_in       = vec_b[if_b.sel];
  assign if_a.start      = st[0];
  assign if_b.start      = st[1];
  assign if_a.continuous = ct[0];
  assign if_b.continuous = ct[1];
  assign vld[0]          = if_a.valid;
  assign vld[1]          = if_b.valid;

  // model: t = edges since the frame's start edge; frame spans 4*d RUN edges + DONE
  typedef struct {bit act; int t; logic [3:0] sh; logic [3:0] smp; int cnt;} m_t;
  m_t ma, mb;

  function automatic m_t step(m_t m, logic s, logic c, logic [3:0] v, int d, int cw);
    m_t r = m;
    if (!m.act) begin
      if (s) begin r.act = 1'b1; r.t = 0; end
    end else begin
      r.t = m.t + 1;
      if (r.t <= 4*d && (r.t % d) == 0) r.sh[r.t/d - 1] = v[r.t/d - 1];
      if (r.t == 4*d) r.smp = r.sh;
      if (r.t == 4*d + 1) begin
        r.cnt = (m.cnt + 1) % (1 << cw);
        r.t   = 0;
        r.act = c;
      end
    end
    return r;
  endfunction

  function automatic int e_sel(m_t m, int d);
    return m.act ? ((m.t >= 4*d) ? 3 : m.t / d) : 0;
  endfunction

  function automatic int e_vld(m_t m, int d);
    return (m.act && m.t == 4*d) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst_a)
    if (rst_a) ma <= '{default:0};
    else       ma <= step(ma, st[0], ct[0], vec_a, 4, 8);

  always @(posedge clk or posedge rst_b)
    if (rst_b) mb <= '{default:0};
    else       mb <= step(mb, st[1], ct[1], vec_b, 1, 2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("a_sel",   32'(if_a.sel),       32'(e_sel(ma, 4)));
    check("a_busy",  32'(if_a.busy),      32'(ma.act));
    check("a_valid", 32'(if_a.valid),     32'(e_vld(ma, 4)));
    check("a_smp",   32'(if_a.sample),    32'(ma.smp));
    check("a_cnt",   32'(if_a.frame_cnt), 32'(ma.cnt));
    check("b_sel",   32'(if_b.sel),       32'(e_sel(mb, 1)));
    check("b_busy",  32'(if_b.busy),      32'(mb.act));
    check("b_valid", 32'(if_b.valid),     32'(e_vld(mb, 1)));
    check("b_smp",   32'(if_b.sample),    32'(mb.smp));
    check("b_cnt",   32'(if_b.frame_cnt), 32'(mb.cnt));
  end

  // lat counts falling edges from the call until valid is seen (bounded)
  task automatic wait_valid(input int i, input bit rep, input int drop, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
      st[i] = rep && (l == 3 || l == 9);
      if (l == drop) ct[i] = 1'b0;
    end while (!vld[i] && l < 40);
    st[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  logic [3:0] vb [5] = '{4'b1011, 4'b0100, 4'b1111, 4'b0010, 4'b1001};
  int         cb [5] = '{0, 1, 2, 3, 0};

  initial begin
    st[0] = 0; st[1] = 0; ct[0] = 0; ct[1] = 0;
    vec_a = '0; vec_b = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("rst_sel",   32'(if_a.sel), 0);
    check("rst_busy",  32'(if_a.busy), 0);
    check("rst_valid", 32'(if_a.valid), 0);
    check("rst_smp",   32'(if_a.sample), 0);
    check("rst_cnt",   32'(if_a.frame_cnt), 0);

    // single scan, a=1 only
    vec_a = 4'b0001; st[0] = 1'b1;
    wait_valid(0, 1'b0, -1, lat);
    check("t1_lat", 32'(lat), 17);
    check("t1_smp", 32'(if_a.sample), 32'h1);
    @(negedge clk);
    check("t1_busy_after", 32'(if_a.busy), 0);
    check("t1_cnt", 32'(if_a.frame_cnt), 1);

    // start re-pulsed mid-frame is ignored
    st[0] = 1'b1;
    wait_valid(0, 1'b1, -1, lat);
    check("t3_lat", 32'(lat), 17);
    check("t3_smp", 32'(if_a.sample), 32'h1);
    @(negedge clk);
    check("t3_cnt", 32'(if_a.frame_cnt), 2);

    // continuous, three frames, continuous dropped inside the third
    vec_a = 4'b0110; ct[0] = 1'b1; st[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(0, 1'b0, (k == 2) ? 5 : -1, lat);
      check("t2_period", 32'(lat), 17);
      check("t2_smp", 32'(if_a.sample), 32'h6);
    end
    @(negedge clk);
    check("t2_idle", 32'(if_a.busy), 0);
    check("t2_cnt", 32'(if_a.frame_cnt), 5);

    // asynchronous reset while sel = 2
    st[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      st[0] = 1'b0;
      if (if_a.sel == 2'd2) break;
    end
    check("t4_reach_sel2", 32'(if_a.sel), 2);
    #2 rst_a = 1'b1;
    #1;
    check("t4_sel",   32'(if_a.sel), 0);
    check("t4_busy",  32'(if_a.busy), 0);
    check("t4_valid", 32'(if_a.valid), 0);
    check("t4_smp",   32'(if_a.sample), 0);
    check("t4_cnt",   32'(if_a.frame_cnt), 0);
    @(negedge clk);
    rst_a = 1'b0;
    nv = 0;
    repeat (25) begin
      @(negedge clk);
      if (if_a.valid) nv++;
    end
    check("t4_no_valid", 32'(nv), 0);

    // DWELL=1, CNT_W=2: five back-to-back frames, new inputs per frame
    rst_b = 1'b0;
    @(negedge clk);
    vec_b = vb[0]; ct[1] = 1'b1; st[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(1, 1'b0, (k == 4) ? 2 : -1, lat);
      check("t5_period", 32'(lat), 5);
      check("t5_smp", 32'(if_b.sample), 32'(vb[k]));
      check("t5_cnt", 32'(if_b.frame_cnt), 32'(cb[k]));
      if (k < 4) vec_b = vb[k+1];
    end
    @(negedge clk);
    check("t5_idle", 32'(if_b.busy), 0);
    check("t5_cnt_wrap", 32'(if_b.frame_cnt), 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
